// File: rtl/jesd_tx_pkg.sv
// jesd_tx_pkg: state encoding, K-characters and limits shared by the JESD204B TX sequencer.
package jesd_tx_pkg;

    typedef enum logic [1:0] {
        ST_CGS       = 2'd0,
        ST_WAIT_LMFC = 2'd1,
        ST_ILAS      = 2'd2,
        ST_DATA      = 2'd3
    } state_e;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_7 = 8'hFC;

    // F-1 for the fixed two-octet frame
    localparam logic [7:0] F_ENC   = 8'h01;
    localparam int         ILAS_MF = 4;
    localparam logic [4:0] K_MIN   = 5'd8;

endpackage

// File: rtl/jesd_tx_ilas_seq_if.sv
// jesd_tx_ilas_seq_if: transport-side octet input and link-side octet/K-flag output of the sequencer.
interface jesd_tx_ilas_seq_if;

    logic [7:0] i_data;
    logic       o_data_rd;
    logic [7:0] o_data;
    logic       o_charisk;

    modport master (input i_data, output o_data_rd, o_data, o_charisk);
    modport slave  (output i_data, input o_data_rd, o_data, o_charisk);

endinterface

// File: rtl/jesd_ilas_cfg_rom.sv
// jesd_ilas_cfg_rom: ILAS link-configuration octets 0..13 including the FCHK field checksum.
module jesd_ilas_cfg_rom
    import jesd_tx_pkg::*;
#(
    parameter logic [7:0] DID       = 8'h00,
    parameter logic [3:0] BID       = 4'h0,
    parameter logic [4:0] LID       = 5'h00,
    parameter logic [4:0] L_ENC     = 5'h00,
    parameter logic       SCR       = 1'b0,
    parameter logic [7:0] M_ENC     = 8'h00,
    parameter logic [4:0] N_ENC     = 5'h0F,
    parameter logic [4:0] NP_ENC    = 5'h0F,
    parameter logic [1:0] CS        = 2'd0,
    parameter logic [4:0] S_ENC     = 5'h00,
    parameter logic [2:0] SUBCLASSV = 3'd1,
    parameter logic [2:0] JESDV     = 3'd1,
    parameter logic       HD        = 1'b0,
    parameter logic [4:0] CF        = 5'h00
) (
    input  logic [3:0] idx_i,
    input  logic [4:0] k_i,
    output logic [7:0] octet_o
);

    logic [7:0] fchk;

    // FCHK sums field values, not packed octets
    assign fchk = DID + 8'(BID) + 8'(LID) + 8'(L_ENC) + 8'(SCR) + F_ENC + 8'(k_i) + M_ENC
                + 8'(N_ENC) + 8'(CS) + 8'(NP_ENC) + 8'(SUBCLASSV) + 8'(S_ENC) + 8'(JESDV)
                + 8'(HD) + 8'(CF);

    always_comb begin
        octet_o = 8'h00;
        case (idx_i)
            4'd0:    octet_o = DID;
            4'd1:    octet_o = {4'h0, BID};
            4'd2:    octet_o = {3'b0, LID};
            4'd3:    octet_o = {SCR, 2'b0, L_ENC};
            4'd4:    octet_o = F_ENC;
            4'd5:    octet_o = {3'b0, k_i};
            4'd6:    octet_o = M_ENC;
            4'd7:    octet_o = {CS, 1'b0, N_ENC};
            4'd8:    octet_o = {SUBCLASSV, NP_ENC};
            4'd9:    octet_o = {JESDV, S_ENC};
            4'd10:   octet_o = {HD, 2'b0, CF};
            4'd13:   octet_o = fchk;
            default: octet_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/jesd_tx_ilas_seq.sv
// jesd_tx_ilas_seq: JESD204B TX link sequencer (CGS -> LMFC-aligned 4-multiframe ILAS -> data).
// Define JESD_TX_CHAR_REPLACE_EN to enable frame/multiframe-end character replacement in DATA.
module jesd_tx_ilas_seq
    import jesd_tx_pkg::*;
#(
    parameter logic [7:0] DID       = 8'h00,
    parameter logic [3:0] BID       = 4'h0,
    parameter logic [4:0] LID       = 5'h00,
    parameter logic [4:0] L_ENC     = 5'h00,
    parameter logic       SCR       = 1'b0,
    parameter logic [7:0] M_ENC     = 8'h00,
    parameter logic [4:0] N_ENC     = 5'h0F,
    parameter logic [4:0] NP_ENC    = 5'h0F,
    parameter logic [1:0] CS        = 2'd0,
    parameter logic [4:0] S_ENC     = 5'h00,
    parameter logic [2:0] SUBCLASSV = 3'd1,
    parameter logic [2:0] JESDV     = 3'd1,
    parameter logic       HD        = 1'b0,
    parameter logic [4:0] CF        = 5'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         i_K,
    input  logic               i_frame_clk,
    input  logic               i_lmfc_clk,
    input  logic               i_sync_n,
    jesd_tx_ilas_seq_if.master bus,
    output logic [1:0]         o_state,
    output logic               o_cfg_err
);

    state_e     state_q, state_d;
    logic [5:0] oct_q, oct_d;
    logic [1:0] mf_q, mf_d;
    logic [7:0] data_q, data_d;
    logic       k_q, k_d;
    logic       cfg_err_q;
    logic [7:0] cfg_oct, ilas_data, dat_data;
    logic       ilas_k, dat_k, first, last, q_slot, cfg_win;

    // frame pulses re-pin the even octet so the counter stays frame-locked
    assign oct_d = i_lmfc_clk ? 6'd0 : i_frame_clk ? {oct_q[5:1] + 5'd1, 1'b0} : oct_q + 6'd1;
    assign mf_d  = state_q != ST_ILAS ? 2'd0 : mf_q + 2'(i_lmfc_clk);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CGS:       state_d = (i_sync_n && i_K >= K_MIN) ? (i_lmfc_clk ? ST_ILAS : ST_WAIT_LMFC) : ST_CGS;
            ST_WAIT_LMFC: state_d = !i_sync_n ? ST_CGS : i_lmfc_clk ? ST_ILAS : ST_WAIT_LMFC;
            ST_ILAS:      state_d = !i_sync_n ? ST_CGS : (i_lmfc_clk && mf_q == 2'(ILAS_MF - 1)) ? ST_DATA : ST_ILAS;
            ST_DATA:      state_d = i_sync_n ? ST_DATA : ST_CGS;
            default:      state_d = ST_CGS;
        endcase
    end

    jesd_ilas_cfg_rom #(
        .DID(DID), .BID(BID), .LID(LID), .L_ENC(L_ENC), .SCR(SCR), .M_ENC(M_ENC),
        .N_ENC(N_ENC), .NP_ENC(NP_ENC), .CS(CS), .S_ENC(S_ENC), .SUBCLASSV(SUBCLASSV),
        .JESDV(JESDV), .HD(HD), .CF(CF)
    ) u_cfg_rom (
        .idx_i   (4'(oct_d - 6'd2)),
        .k_i     (i_K),
        .octet_o (cfg_oct)
    );

    assign first     = oct_d == 6'd0;
    assign last      = oct_d == {i_K, 1'b1};
    assign q_slot    = mf_d == 2'd1 && oct_d == 6'd1;
    assign cfg_win   = mf_d == 2'd1 && oct_d >= 6'd2 && oct_d <= 6'd15;
    assign ilas_data = first ? K28_0 : last ? K28_3 : q_slot ? K28_4 : cfg_win ? cfg_oct : {2'b0, oct_d};
    assign ilas_k    = first || last || q_slot;

`ifdef JESD_TX_CHAR_REPLACE_EN
    logic [7:0] ref_q;
    logic       ref_v_q, rep;

    assign rep      = ref_v_q && oct_d[0] && bus.i_data == ref_q;
    assign dat_data = rep ? (last ? K28_3 : K28_7) : bus.i_data;
    assign dat_k    = rep;

    // reference is always the original frame-end octet, never the substitute
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q   <= 8'h00;
            ref_v_q <= 1'b0;
        end else begin
            ref_v_q <= state_d == ST_DATA && (ref_v_q || oct_d[0]);
            if (state_d == ST_DATA && oct_d[0]) ref_q <= bus.i_data;
        end
    end
`else
    assign dat_data = bus.i_data;
    assign dat_k    = 1'b0;
`endif

    assign data_d = state_d == ST_ILAS ? ilas_data : state_d == ST_DATA ? dat_data : K28_5;
    assign k_d    = state_d == ST_ILAS ? ilas_k : state_d == ST_DATA ? dat_k : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CGS;
            oct_q     <= 6'd0;
            mf_q      <= 2'd0;
            data_q    <= K28_5;
            k_q       <= 1'b1;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            oct_q     <= oct_d;
            mf_q      <= mf_d;
            data_q    <= data_d;
            k_q       <= k_d;
            cfg_err_q <= i_K < K_MIN;
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_charisk = k_q;
    assign bus.o_data_rd = state_q == ST_DATA && i_sync_n;
    assign o_state       = state_q;
    assign o_cfg_err     = cfg_err_q;

endmodule

// File: doc/jesd_tx_ilas_seq.md
Name: jesd_tx_ilas_seq

Overview:
- JESD204B transmit link-layer sequencer.
- Sits directly downstream of the frame/LMFC clock generator and consumes its one-cycle o_frame_clk/o_lmfc_clk pulses.
- Drives code-group synchronisation (CGS) on SYNC~ request, then the 4-multiframe ILAS aligned to LMFC, then user data.
- Output is one octet per device clock plus K-flag, feeding the 8b/10b encoder. F = 2 octets/frame, fixed by the 2:1 frame clock.

Parameters:
- DID, 8'h00, device ID (ILAS octet 0)
- BID, 4'h0, bank ID
- LID, 5'h00, lane ID
- L_ENC, 5'h00, lanes-1
- SCR, 1'b0, scrambling flag (advertised only)
- M_ENC, 8'h00, converters-1
- N_ENC, 5'h0F, resolution-1
- NP_ENC, 5'h0F, N'-1
- CS, 2'd0, control bits
- S_ENC, 5'h00, samples-1
- SUBCLASSV, 3'd1; JESDV, 3'd1; HD, 1'b0; CF, 5'h00

Ports:
- clk  in  1  device clock
- rst  in  1  synchronous active-high reset
- i_K  in  5  frames per multiframe minus 1 (same encoding as the clock generator)
- i_frame_clk  in  1  one-cycle frame-start pulse
- i_lmfc_clk  in  1  one-cycle multiframe-start pulse, coincident with an i_frame_clk pulse
- i_sync_n  in  1  SYNC~ from receiver, active low, already synchronised to clk
- i_data  in  8  transport-layer octet
- o_data_rd  out  1  i_data consumed this cycle
- o_data  out  8  link octet
- o_charisk  out  1  o_data is a K-character
- o_state  out  2  current state (debug)
- o_cfg_err  out  1  i_K below the ILAS minimum

Behaviour:
- Reset: state=CGS, o_data=8'hBC, o_charisk=1, o_data_rd=0, o_cfg_err=0, octet counter=0.
- Octet counter oct: cleared when i_lmfc_clk=1, otherwise incremented. Multiframe length MFL=2*(i_K+1) octets. Counter is 6 bits and must not wrap before MFL.
- Multiframe counter mf (2 bits) counts ILAS multiframes.
- All outputs are registered. The octet with index oct is emitted in the cycle after oct is computed, so each LMFC pulse yields octet 0 of the new multiframe one clk later.
- States:
  - CGS (0): emit K28.5 (BC, k=1). Leave only when i_sync_n=1 and i_K>=8. If i_K<8, hold o_cfg_err=1 and stay in CGS.
  - WAIT_LMFC (1): keep emitting K28.5. On i_lmfc_clk=1 go to ILAS with mf=0. If sync_n rise and lmfc pulse occur in the same cycle, go to ILAS at that boundary.
  - ILAS (2): 4 multiframes. On each one:
    - oct 0 = /R/ 1C k=1
    - oct MFL-1 = /A/ 7C k=1
    - other octets = oct value, k=0
    - on mf=1 only: oct 1 = /Q/ 9C k=1; oct 2..15 = config octets 0..13
    - On the lmfc pulse ending mf=3, go to DATA.
  - DATA (3): o_data_rd=1. o_data=i_data registered (1-cycle latency), k=0.
- Config octets:
  - 0 DID
  - 1 {4'h0,BID}
  - 2 {3'b0,LID}
  - 3 {SCR,2'b0,L_ENC}
  - 4 8'h01
  - 5 {3'b0,i_K}
  - 6 M_ENC
  - 7 {CS,1'b0,N_ENC}
  - 8 {SUBCLASSV,NP_ENC}
  - 9 {JESDV,S_ENC}
  - 10 {HD,2'b0,CF}
  - 11, 12: 00
  - 13 FCHK = sum of all field values mod 256, per JESD204B
- i_sync_n=0 in WAIT_LMFC, ILAS or DATA: CGS from the next cycle, with o_data_rd=0 immediately.
- i_K change outside CGS is undefined. rst mid-sequence returns to the reset state next edge.

Optional Feature:
- JESD_TX_CHAR_REPLACE_EN:
  - When defined, DATA state applies JESD204B char replacement (scrambling off).
  - If the last octet of a multiframe equals the last octet of the previous frame, send 7C k=1.
  - Else, if a frame's last octet equals the previous frame's last octet, send FC k=1.
  - A replaced octet is never the reference for the next comparison; the original value is.
  - Undefined: data passes unmodified, k=0 always.

Decomposition:
- Package jesd_tx_pkg: state encoding, K-char constants (K28_5=BC, K28_0=1C, K28_3=7C, K28_4=9C, K28_7=FC), ILAS_MF=4, K_MIN=8.
- Sub-module jesd_ilas_cfg_rom: combinational config-octet/FCHK generator indexed by oct-2.

Test Plan:
- Reset, i_sync_n=0, i_K=15: o_data=BC k=1 continuously, o_state=0, o_data_rd=0.
- i_K=15 (MFL=32), sync_n rises mid-multiframe: BC continues until the lmfc pulse, then ILAS octet 0=1C. Octet 31=7C; mf1 octet1=9C, octet 2=DID, octet 7=8'h0F (K), octet 15=FCHK. After 128 ILAS octets, o_data_rd=1 and o_data follows i_data 1 clk later.
- i_K=5: o_cfg_err=1 and CGS held regardless of i_sync_n.
- sync_n rise on the same cycle as the lmfc pulse: ILAS starts at that boundary with no extra multiframe wait.
- sync_n dropped during ILAS mf=2 and during DATA: BC on the next cycle, o_data_rd=0; re-release restarts the full ILAS.
- JESD_TX_CHAR_REPLACE_EN, i_data constant 55: frame-end octets become FC, multiframe-end octets become 7C; without the macro, all octets are 55 k=0.
